tablero_disparos: RTL and testbench

Fleet-board owner for the Battleship datapath: it accepts ship placements, then applies incoming shots to the board. It produces the 5x5 `barcos` segment matrix that the sunk-ship register consumes, where row k is ship k and a row of all zeros means that ship is destroyed. It is the writer of that matrix, and it also returns a per-shot hit, miss or sunk result to the game controller.

---
 rtl/tablero_disparos.sv | 122 ++++++++++++
 tb/tb_tablero_disparos.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tablero_disparos.sv
// tablero_disparos: Battleship fleet board; validates/writes ship placements and resolves shots into hit/miss/sunk.
// Ports: clk, rst (async active-low); placement handshake place_valid/place_ready with place_id/row/col/len/vert,
// answered by place_done/place_err; shot handshake shot_valid/shot_ready with shot_row/col, answered by
// res_valid/res_hit/res_sunk/res_repeat/res_id; barcos segment matrix (row k = ship k); flota_lista; fin_juego.
module tablero_disparos #(
  parameter int NUM_BARCOS = 5,
  parameter int BOARD = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic place_valid,
  output logic place_ready,
  input  logic [2:0] place_id,
  input  logic [2:0] place_row,
  input  logic [2:0] place_col,
  input  logic [2:0] place_len,
  input  logic place_vert,
  output logic place_done,
  output logic place_err,
  input  logic shot_valid,
  output logic shot_ready,
  input  logic [2:0] shot_row,
  input  logic [2:0] shot_col,
  output logic res_valid,
  output logic res_hit,
  output logic res_sunk,
  output logic res_repeat,
  output logic [2:0] res_id,
  output logic [NUM_BARCOS-1:0][BOARD-1:0] barcos,
  output logic flota_lista,
  output logic fin_juego
);
  typedef enum logic [1:0] {IDLE, CHK, WR, DONE} state_t;
  localparam logic [3:0] B = 4'(BOARD);
  localparam logic [3:0] N = 4'(NUM_BARCOS);
  state_t state, state_nx;
  logic [6:0] grid [BOARD][BOARD];
  logic [NUM_BARCOS-1:0] placed;
  logic [2:0] rid, rrow, rcol, rlen, i;
  logic rvert, err;
  logic [3:0] cr, cc;
  logic bad_req, cell_bad, last, place_hs, shot_hs, shot_in, shot_live;
  logic [6:0] shot_cell;
  logic [2:0] sk, sj;
  assign flota_lista = &placed;
  assign fin_juego = flota_lista & ~|barcos;
  assign place_ready = (state == IDLE) & ~flota_lista;
  assign shot_ready = (state == IDLE) & flota_lista & ~fin_juego;
  assign place_done = state == DONE;
  assign place_err = place_done & err;
  assign place_hs = place_valid & place_ready;
  assign shot_hs = shot_valid & shot_ready;
  assign bad_req = {1'b0, place_id} >= N || placed[place_id] || place_len == 3'd0 || {1'b0, place_len} > B;
  assign cr = {1'b0, rrow} + (rvert ? {1'b0, i} : 4'd0);
  assign cc = {1'b0, rcol} + (rvert ? 4'd0 : {1'b0, i});
  // bounds are tested on the 4-bit sums; the grid read only matters when in bounds
  assign cell_bad = cr >= B || cc >= B || grid[cr[2:0]][cc[2:0]][6];
  assign last = i == rlen - 3'd1;
  assign shot_in = {1'b0, shot_row} < B && {1'b0, shot_col} < B;
  assign shot_cell = shot_in ? grid[shot_row][shot_col] : 7'd0;
  assign sk = shot_cell[5:3];
  assign sj = shot_cell[2:0];
  assign shot_live = shot_cell[6] & barcos[sk][sj];
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = place_hs ? (bad_req ? DONE : CHK) : IDLE;
      CHK: state_nx = cell_bad ? DONE : (last ? WR : CHK);
      WR: state_nx = last ? DONE : WR;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int r = 0; r < BOARD; r++)
        for (int c = 0; c < BOARD; c++)
          grid[r][c] <= '0;
      placed <= '0;
      barcos <= '0;
      rid <= '0;
      rrow <= '0;
      rcol <= '0;
      rlen <= '0;
      rvert <= 1'b0;
      i <= '0;
      err <= 1'b0;
      res_valid <= 1'b0;
      res_hit <= 1'b0;
      res_sunk <= 1'b0;
      res_repeat <= 1'b0;
      res_id <= '0;
    end else begin
      res_valid <= shot_hs;
      res_hit <= shot_hs & shot_cell[6];
      res_repeat <= shot_hs & shot_cell[6] & ~barcos[sk][sj];
      res_sunk <= shot_hs & shot_live & ((barcos[sk] & ~(BOARD'(1) << sj)) == '0);
      res_id <= shot_hs & shot_cell[6] ? sk : 3'd0;
      if (shot_hs & shot_live) barcos[sk][sj] <= 1'b0;
      if (place_hs) begin
        rid <= place_id;
        rrow <= place_row;
        rcol <= place_col;
        rlen <= place_len;
        rvert <= place_vert;
        i <= '0;
        err <= bad_req;
      end
      if (state == CHK) begin
        if (cell_bad) err <= 1'b1;
        else i <= last ? 3'd0 : i + 3'd1;
      end
      if (state == WR) begin
        grid[cr[2:0]][cc[2:0]] <= {1'b1, rid, i};
        barcos[rid][i] <= 1'b1;
        i <= i + 3'd1;
        if (last) placed[rid] <= 1'b1;
      end
    end
endmodule

// File: tb/tb_tablero_disparos.sv
// tb_tablero_disparos: scoreboard bench for tablero_disparos against a cell-map reference model.
module tb_tablero_disparos;
  logic clk = 0, rst = 0;
  logic place_valid = 0, place_ready, place_vert = 0, place_done, place_err;
  logic [2:0] place_id = 0, place_row = 0, place_col = 0, place_len = 0;
  logic shot_valid = 0, shot_ready;
  logic [2:0] shot_row = 0, shot_col = 0;
  logic res_valid, res_hit, res_sunk, res_repeat;
  logic [2:0] res_id;
  logic [4:0][4:0] barcos;
  logic flota_lista, fin_juego;

  tablero_disparos dut (
    .clk(clk), .rst(rst),
    .place_valid(place_valid), .place_ready(place_ready), .place_id(place_id),
    .place_row(place_row), .place_col(place_col), .place_len(place_len), .place_vert(place_vert),
    .place_done(place_done), .place_err(place_err),
    .shot_valid(shot_valid), .shot_ready(shot_ready), .shot_row(shot_row), .shot_col(shot_col),
    .res_valid(res_valid), .res_hit(res_hit), .res_sunk(res_sunk), .res_repeat(res_repeat),
    .res_id(res_id), .barcos(barcos), .flota_lista(flota_lista), .fin_juego(fin_juego)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_bad = 0;
  typedef struct {
    logic err, hit, sunk, rep;
    logic [2:0] id;
    logic [24:0] b;
    logic fl, fin;
    int at;
  } exp_t;
  exp_t pq[$], sq[$];
  exp_t pe, se;

  // reference model: who owns each cell, which segment, and which segments survive
  int own [5][5];
  int sg [5][5];
  logic [4:0][4:0] alive;
  logic [4:0] placed_m;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        own[r][c] = -1;
        sg[r][c] = 0;
      end
    alive = '0;
    placed_m = '0;
  endtask

  function automatic bit m_flota();
    return &placed_m;
  endfunction

  function automatic bit m_fin();
    return m_flota() && alive == '0;
  endfunction

  always @(negedge clk) if (rst) begin
    if (place_done) begin
      if (pq.size() == 0) chk("spurious_place_done", 1, 0);
      else begin
        pe = pq.pop_front();
        chk("place_err", place_err, pe.err);
        chk("place_time", cyc, pe.at);
        chk("place_barcos", barcos, pe.b);
        chk("flota_lista", flota_lista, pe.fl);
      end
    end
    if (res_valid) begin
      if (sq.size() == 0) chk("spurious_res_valid", 1, 0);
      else begin
        se = sq.pop_front();
        chk("res_time", cyc, se.at);
        chk("res_hit", res_hit, se.hit);
        chk("res_sunk", res_sunk, se.sunk);
        chk("res_repeat", res_repeat, se.rep);
        chk("res_id", res_id, se.id);
        chk("shot_barcos", barcos, se.b);
        chk("fin_juego", fin_juego, se.fin);
      end
    end
  end

  task automatic drain();
    for (int k = 0; k < 60 && (pq.size() + sq.size()) > 0; k++) @(posedge clk);
    chk("drain_timeout", pq.size() + sq.size(), 0);
    pq.delete();
    sq.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic place(input int id, input int row, input int col, input int len, input bit vert);
    exp_t e;
    bit err;
    int lat, r, c;
    place_id = 3'(id);
    place_row = 3'(row);
    place_col = 3'(col);
    place_len = 3'(len);
    place_vert = vert;
    place_valid = 1;
    if (m_flota()) begin
      repeat (3) @(posedge clk);
      #1 place_valid = 0;
      drain();
      return;
    end
    e = '{default: 0};
    err = 0;
    lat = 2 * len + 1;
    if (id >= 5 || placed_m[id] || len == 0 || len > 5) begin
      err = 1;
      lat = 1;
    end else
      for (int k = 0; k < len; k++) begin
        r = row + (vert ? k : 0);
        c = col + (vert ? 0 : k);
        if (r >= 5 || c >= 5 || own[r][c] >= 0) begin
          err = 1;
          lat = k + 2;
          break;
        end
      end
    if (!err) begin
      for (int k = 0; k < len; k++) begin
        r = row + (vert ? k : 0);
        c = col + (vert ? 0 : k);
        own[r][c] = id;
        sg[r][c] = k;
        alive[id][k] = 1;
      end
      placed_m[id] = 1;
    end
    e.err = err;
    e.b = alive;
    e.fl = m_flota();
    @(posedge clk);
    #1 place_valid = 0;
    e.at = cyc + lat - 1;
    pq.push_back(e);
    drain();
  endtask

  task automatic fire(input int r, input int c);
    exp_t e;
    bit acc;
    int k, j;
    shot_row = 3'(r);
    shot_col = 3'(c);
    shot_valid = 1;
    acc = m_flota() && !m_fin();
    e = '{default: 0};
    if (acc && r < 5 && c < 5 && own[r][c] >= 0) begin
      k = own[r][c];
      j = sg[r][c];
      e.hit = 1;
      e.id = 3'(k);
      if (alive[k][j]) begin
        alive[k][j] = 0;
        e.sunk = alive[k] == '0;
      end else e.rep = 1;
    end
    e.b = alive;
    e.fin = m_fin();
    @(posedge clk);
    #1;
    e.at = cyc;
    if (acc) sq.push_back(e);
  endtask

  int cells[25];
  int idx, burst, t;

  initial begin
    #5000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_barcos", barcos, 0);
    chk("rst_flota", flota_lista, 0);
    chk("rst_fin", fin_juego, 0);
    chk("rst_place_done", place_done, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_shot_ready", shot_ready, 0);
    rst = 1;
    @(posedge clk);
    #1;
    chk("post_rst_shot_ready", shot_ready, 0);
    for (int s = 0; s < 3; s++) place(s, s, 0, 5, 0);
    place_id = 3;
    place_row = 3;
    place_col = 0;
    place_len = 4;
    place_vert = 0;
    place_valid = 1;
    @(posedge clk);
    #1 place_valid = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("wr_partial", barcos[3], 5'b00001);
    rst = 0;
    #1;
    chk("midwr_barcos", barcos, 0);
    chk("midwr_flota", flota_lista, 0);
    chk("midwr_place_done", place_done, 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1;
    place(2, 2, 0, 5, 0);
    fire(1, 1);
    shot_valid = 0;
    drain();
    place(0, 0, 4, 3, 0);
    place(0, 1, 1, 3, 1);
    place(2, 4, 4, 1, 0);
    place(6, 4, 4, 1, 0);
    place(1, 4, 4, 0, 0);
    place(1, 0, 4, 6, 1);
    repeat (4) place($urandom_range(5, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    place(0, 0, 0, 5, 0);
    place(1, 1, 0, 5, 0);
    place(3, 3, 0, 5, 0);
    place(4, 4, 0, 5, 0);
    place(0, 0, 0, 1, 0);
    fire(7, 0);
    fire(0, 6);
    fire(2, 1);
    fire(2, 1);
    shot_valid = 0;
    drain();
    fire(0, 0);
    fire(0, 1);
    fire(1, 4);
    shot_valid = 0;
    drain();
    for (int k = 0; k < 25; k++) cells[k] = k;
    for (int k = 24; k > 0; k--) begin
      idx = $urandom_range(0, k);
      t = cells[k];
      cells[k] = cells[idx];
      cells[idx] = t;
    end
    idx = 0;
    while (idx < 25) begin
      burst = $urandom_range(1, 4);
      for (int b = 0; b < burst && idx < 25; b++) begin
        if ($urandom_range(0, 5) == 0) fire($urandom_range(5, 7), $urandom_range(0, 7));
        fire(cells[idx] / 5, cells[idx] % 5);
        idx++;
      end
      shot_valid = 0;
      drain();
    end
    chk("final_fin", fin_juego, 1);
    chk("final_shot_ready", shot_ready, 0);
    fire(3, 3);
    shot_valid = 0;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
